sdram_ref_sched: RTL and testbench
==================================

# sdram_ref_sched

Parametrised SDRAM auto-refresh scheduler. It tracks refresh debt from a tREFI interval timer, and lets the arbiter postpone refreshes up to a configurable limit. Once granted, it issues one precharge-all followed by a burst of AUTO REFRESH commands sized to the outstanding debt. It sits between the init module (via `ref_init_end`) and the command arbiter, driving the arbiter's refresh command/bank/address inputs.

## Interface
- `T_REFI_CYC`, 780: refresh interval in clock cycles; one refresh is owed per interval.
- `T_RP_CYC`, 2: cycles from the PRE command to the first AR command (≥1).
- `T_RFC_CYC`, 7: cycles from one AR command to the next command (≥1).
- `MAX_DEBT`, 8: saturation limit of postponed refreshes (≥1).
- `URGENT_TH`, 6: debt level at which `ref_urgent` asserts (1..MAX_DEBT).
- `BURST_MAX`, 4: maximum AR commands per grant (1..MAX_DEBT).
- `DW`, `$clog2(MAX_DEBT+1)`: debt counter width (derived).
- `ref_clk` in 1: single clock; all logic is on the rising edge.
- `ref_rst` in 1: synchronous, active-high reset.
- `ref_init_end` in 1: SDRAM initialisation complete; level signal.
- `ref_en` in 1: arbiter grant; sampled only in IDLE.
- `ref_req` out 1: refresh request to the arbiter.
- `ref_urgent` out 1: debt ≥ URGENT_TH; the arbiter must grant ahead of read/write.
- `ref_ack` out 1: one-cycle pulse, grant accepted (PRE cycle).
- `ref_end` out 1: one-cycle pulse, burst complete.
- `ref_cmd` out 4: {CS#, RAS#, CAS#, WE#}.
- `ref_bank` out 2: bank address.
- `ref_addr` out 13: address; A10=1 during PRE selects all banks.
- `ref_debt` out DW: current outstanding refresh count.
- `ref_overflow` out 1: sticky; a tick arrived while debt was already MAX_DEBT.

## Operation
- Command encodings:
  - NOP = 4'b0111.
  - PRE = 4'b0010.
  - AR = 4'b0001.
  - `ref_bank` = 2'b11 and `ref_addr` = 13'h1fff at all times, including reset.
- Interval timer:
  - Counts 0..T_REFI_CYC-1 while `ref_init_end`=1, then wraps.
  - The wrap cycle (count == T_REFI_CYC-1) generates `tick`.
  - While `ref_init_end`=0 the timer is held at 0 and debt is forced to 0.
- Debt counter:
  - `tick` alone: +1, saturating at MAX_DEBT. A tick at MAX_DEBT sets `ref_overflow`, which clears only on reset.
  - An AR issue alone: -1, saturating at 0.
  - `tick` and an AR issue in the same cycle: debt unchanged.
- Burst length: `nburst` = min(debt, BURST_MAX), latched on the PRE cycle. The same cycle's tick does not count.
- FSM states: IDLE, PRE, TRP, AR, TRFC, END.
  - IDLE→PRE when `ref_req` && `ref_en`.
  - PRE→TRP, unconditionally. If T_RP_CYC=1, PRE→AR directly.
  - TRP→AR after T_RP_CYC-1 cycles in TRP.
  - AR→TRFC. If T_RFC_CYC=1, TRFC is skipped.
  - TRFC→AR after T_RFC_CYC-1 cycles if ARs issued < `nburst`; otherwise TRFC→END.
  - END→IDLE.
- Outputs decoded from the current state (registered state, no extra pipeline stage):
  - `ref_cmd`=PRE in PRE, AR in AR, NOP in all other states.
  - `ref_ack`=1 in PRE only.
  - `ref_end`=1 in END only.
- `ref_req` = (state==IDLE) && `ref_init_end` && (debt≠0).
- `ref_urgent` = (debt ≥ URGENT_TH); independent of state.
- `ref_en` outside IDLE, or with `ref_req`=0, is ignored.
- `ref_init_end` falling mid-burst: the burst completes as sequenced and debt stays 0.
- Reset:
  - Values: state IDLE, timer 0, debt 0, `ref_cmd`=NOP, `ref_req`/`ref_urgent`/`ref_ack`/`ref_end`/`ref_overflow`=0, `ref_debt`=0.
  - Reset mid-burst aborts immediately; NOP is driven on the first post-reset cycle.

## Timing
- Grant latency: `ref_en` high in IDLE at cycle G → PRE at G+1, `ref_ack` at G+1, `ref_req` low from G+1.
- With PRE at cycle P:
  - k-th AR (k=0..nburst-1) at P+T_RP_CYC+k·T_RFC_CYC.
  - END at P+T_RP_CYC+nburst·T_RFC_CYC.
  - IDLE at END+1. `ref_req` may reassert at END+1 if debt≠0.
- Command spacing: PRE→AR ≥ T_RP_CYC; AR→AR and last AR→any next command ≥ T_RFC_CYC.
- Debt update is visible on `ref_debt` the cycle after the tick or AR cycle.
- First tick after `ref_init_end` rises at cycle R (first sampled high): R+T_REFI_CYC-1; `ref_req` high at R+T_REFI_CYC.

## Test plan
- Basic (defaults), `ref_init_end` rising at cycle 0, `ref_en` tied high → `ref_req` at 780, PRE at 781, AR at 783, `ref_end` at 790, `ref_debt` returns to 0 at 784.
- Postpone: `ref_en`=0 for 6 intervals → `ref_debt`=6 and `ref_urgent`=1; then grant → 4 ARs spaced 7 cycles apart, `ref_debt`=2, `ref_req` reasserts the cycle after `ref_end`, and a second grant issues 2 ARs.
- Overflow: `ref_en`=0 for 9 intervals → `ref_debt` saturates at 8, `ref_overflow`=1 from the 9th tick, `ref_overflow` stays 1 after the debt drains, and clears only on `ref_rst`.
- Simultaneous: align a grant so an AR coincides with a tick → `ref_debt` unchanged that cycle; a burst latched at 1 issues exactly 1 AR.
- Reset mid-TRFC: assert `ref_rst` for 1 cycle during a burst → next cycle `ref_cmd`=NOP, all outputs at reset values, timer restarts from 0.
- No init: `ref_init_end`=0 for 5000 cycles with `ref_en`=1 → `ref_req`, `ref_debt`, `ref_cmd` remain at 0/0/NOP.

Source files
------------

// File: rtl/sdram_ref_sched.sv
// SDRAM auto-refresh scheduler.
// Counts owed refreshes from a tREFI timer and lets the arbiter postpone them.
// On a grant it issues one precharge-all, then a burst of AUTO REFRESH commands
// sized to the debt latched at the PRE cycle.
//
// Handshake: ref_req is high while the scheduler is IDLE, initialised and owes
// at least one refresh. A grant occurs on any clock edge where ref_req and
// ref_en are both high. ref_en is ignored at all other times. ref_ack pulses on
// the PRE cycle that follows the grant, and ref_end pulses when the burst is done.
module sdram_ref_sched #(
   parameter int T_REFI_CYC = 780,
   parameter int T_RP_CYC   = 2,
   parameter int T_RFC_CYC  = 7,
   parameter int MAX_DEBT   = 8,
   parameter int URGENT_TH  = 6,
   parameter int BURST_MAX  = 4,
   parameter int DW         = $clog2(MAX_DEBT + 1)
) (
   input  logic          ref_clk,
   input  logic          ref_rst,
   input  logic          ref_init_end,
   input  logic          ref_en,
   output logic          ref_req,
   output logic          ref_urgent,
   output logic          ref_ack,
   output logic          ref_end,
   output logic [3:0]    ref_cmd,
   output logic [1:0]    ref_bank,
   output logic [12:0]   ref_addr,
   output logic [DW-1:0] ref_debt,
   output logic          ref_overflow,
   output logic [2:0]    ref_state
);

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_AR  = 4'b0001;

   localparam int TW     = $clog2(T_REFI_CYC + 1);
   localparam int WMAX   = (T_RP_CYC > T_RFC_CYC) ? T_RP_CYC : T_RFC_CYC;
   localparam int WW     = $clog2(WMAX + 1);

   localparam logic [TW-1:0] TIMER_LAST = TW'(T_REFI_CYC - 1);
   // Wait counters count down to zero; a state lasting N cycles loads N-1.
   localparam logic [WW-1:0] RP_LOAD    = (T_RP_CYC > 1)  ? WW'(T_RP_CYC - 2)  : '0;
   localparam logic [WW-1:0] RFC_LOAD   = (T_RFC_CYC > 1) ? WW'(T_RFC_CYC - 2) : '0;
   localparam logic [DW-1:0] D_MAX      = DW'(MAX_DEBT);
   localparam logic [DW-1:0] D_URG      = DW'(URGENT_TH);
   localparam logic [DW-1:0] D_BURST    = DW'(BURST_MAX);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_TRP  = 3'd2,
      S_AR   = 3'd3,
      S_TRFC = 3'd4,
      S_END  = 3'd5
   } state_t;

   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic [DW-1:0] r_debt;
   logic          r_overflow;
   logic [WW-1:0] r_wait;
   logic [DW-1:0] r_nburst;
   logic [DW-1:0] r_ar_cnt;

   logic          w_tick;
   logic          w_ar_issue;
   logic [DW-1:0] w_ar_next;

   assign w_tick     = ref_init_end && (r_timer == TIMER_LAST);
   assign w_ar_issue = (r_state == S_AR);
   assign w_ar_next  = r_ar_cnt + DW'(1);

   // Interval timer: free-runs while initialised, held at zero otherwise.
   always_ff @(posedge ref_clk) begin
      if (ref_rst || !ref_init_end) begin
         r_timer <= '0;
      end else if (w_tick) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + TW'(1);
      end
   end

   // Refresh debt: tick adds one, AR removes one, both together cancel.
   always_ff @(posedge ref_clk) begin
      if (ref_rst) begin
         r_debt     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_tick && (r_debt == D_MAX)) begin
            r_overflow <= 1'b1;
         end
         if (!ref_init_end) begin
            r_debt <= '0;
         end else if (w_tick && !w_ar_issue) begin
            if (r_debt != D_MAX) r_debt <= r_debt + DW'(1);
         end else if (w_ar_issue && !w_tick) begin
            if (r_debt != '0) r_debt <= r_debt - DW'(1);
         end
      end
   end

   // Command sequencer: PRE, tRP wait, then AR / tRFC pairs until the burst is done.
   always_ff @(posedge ref_clk) begin
      if (ref_rst) begin
         r_state  <= S_IDLE;
         r_wait   <= '0;
         r_nburst <= '0;
         r_ar_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (ref_req && ref_en) r_state <= S_PRE;
            end
            S_PRE: begin
               r_nburst <= (r_debt > D_BURST) ? D_BURST : r_debt;
               r_ar_cnt <= '0;
               r_wait   <= RP_LOAD;
               r_state  <= (T_RP_CYC > 1) ? S_TRP : S_AR;
            end
            S_TRP: begin
               if (r_wait == '0) r_state <= S_AR;
               else              r_wait  <= r_wait - WW'(1);
            end
            S_AR: begin
               r_ar_cnt <= w_ar_next;
               r_wait   <= RFC_LOAD;
               if (T_RFC_CYC > 1)           r_state <= S_TRFC;
               else if (w_ar_next < r_nburst) r_state <= S_AR;
               else                         r_state <= S_END;
            end
            S_TRFC: begin
               if (r_wait == '0) begin
                  r_state <= (r_ar_cnt < r_nburst) ? S_AR : S_END;
               end else begin
                  r_wait <= r_wait - WW'(1);
               end
            end
            S_END: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Command bus decoded straight from the registered state.
   always_comb begin
      ref_cmd = CMD_NOP;
      case (r_state)
         S_PRE:   ref_cmd = CMD_PRE;
         S_AR:    ref_cmd = CMD_AR;
         default: ref_cmd = CMD_NOP;
      endcase
   end

   assign ref_req      = (r_state == S_IDLE) && ref_init_end && (r_debt != '0);
   assign ref_urgent   = (r_debt >= D_URG);
   assign ref_ack      = (r_state == S_PRE);
   assign ref_end      = (r_state == S_END);
   assign ref_bank     = 2'b11;
   assign ref_addr     = 13'h1fff;
   assign ref_debt     = r_debt;
   assign ref_overflow = r_overflow;
   assign ref_state    = r_state;

endmodule

// File: tb/tb_sdram_ref_sched.sv
// Bench for sdram_ref_sched at default parameters.
// Commands and burst-end pulses are matched against an expected queue of
// {cycle, command} entries pushed whenever a grant is set up.
module tb_sdram_ref_sched;

   localparam int unsigned T_REFI = 780;
   localparam int unsigned T_RP   = 2;
   localparam int unsigned T_RFC  = 7;
   localparam logic [3:0] NOP     = 4'b0111;
   localparam logic [3:0] PRE     = 4'b0010;
   localparam logic [3:0] AR      = 4'b0001;
   localparam logic [3:0] END_TAG = 4'b1110;

   logic        ref_clk = 1'b0;
   logic        ref_rst;
   logic        ref_init_end;
   logic        ref_en;
   logic        ref_req;
   logic        ref_urgent;
   logic        ref_ack;
   logic        ref_end;
   logic [3:0]  ref_cmd;
   logic [1:0]  ref_bank;
   logic [12:0] ref_addr;
   logic [3:0]  ref_debt;
   logic        ref_overflow;
   logic [2:0]  ref_state;

   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;
   logic [35:0] exp_q[$];

   sdram_ref_sched dut (
      .ref_clk      (ref_clk),
      .ref_rst      (ref_rst),
      .ref_init_end (ref_init_end),
      .ref_en       (ref_en),
      .ref_req      (ref_req),
      .ref_urgent   (ref_urgent),
      .ref_ack      (ref_ack),
      .ref_end      (ref_end),
      .ref_cmd      (ref_cmd),
      .ref_bank     (ref_bank),
      .ref_addr     (ref_addr),
      .ref_debt     (ref_debt),
      .ref_overflow (ref_overflow),
      .ref_state    (ref_state)
   );

   // Clock and cycle counter.
   always #5 ref_clk = ~ref_clk;
   always @(posedge ref_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic wait_until(input int unsigned t);
      while (cyc < t) @(negedge ref_clk);
   endtask

   task automatic push_ev(input int unsigned t, input logic [3:0] tag);
      logic [31:0] tt;
      tt = t;
      exp_q.push_back({tt, tag});
   endtask

   // Expected PRE at p, ARs every tRFC after tRP, END after the last tRFC.
   task automatic push_burst(input int unsigned p, input int unsigned nb);
      push_ev(p, PRE);
      for (int unsigned k = 0; k < nb; k++) push_ev(p + T_RP + k * T_RFC, AR);
      push_ev(p + T_RP + nb * T_RFC, END_TAG);
   endtask

   task automatic sb_pop(input logic [3:0] tag);
      logic [35:0] e;
      if (exp_q.size() == 0) begin
         check("sb_unexpected", 32'(tag), 32'(NOP));
      end else begin
         e = exp_q.pop_front();
         check("sb_cmd", 32'(tag), 32'(e[3:0]));
         check("sb_cyc", cyc, e[35:4]);
         if (tag == PRE) check("ack_on_pre", 32'(ref_ack), 32'd1);
      end
   endtask

   // Scoreboard monitor: every command and burst end must match the queue head.
   always @(negedge ref_clk) begin
      if (ref_cmd !== NOP) sb_pop(ref_cmd);
      if (ref_end === 1'b1) sb_pop(END_TAG);
   end

   initial begin
      int unsigned c0;
      int unsigned p;
      int unsigned q;

      ref_rst      = 1'b1;
      ref_init_end = 1'b0;
      ref_en       = 1'b0;
      repeat (3) @(negedge ref_clk);

      // Reset values
      check("rst_cmd",  32'(ref_cmd), 32'(NOP));
      check("rst_req",  32'(ref_req), 32'd0);
      check("rst_urg",  32'(ref_urgent), 32'd0);
      check("rst_ack",  32'(ref_ack), 32'd0);
      check("rst_end",  32'(ref_end), 32'd0);
      check("rst_ovf",  32'(ref_overflow), 32'd0);
      check("rst_debt", 32'(ref_debt), 32'd0);
      check("rst_bank", 32'(ref_bank), 32'h3);
      check("rst_addr", 32'(ref_addr), 32'h1fff);
      check("rst_state", 32'(ref_state), 32'd0);
      ref_rst = 1'b0;

      // No init: grant held high, nothing may happen
      ref_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         repeat (1000) @(negedge ref_clk);
         check("noinit_req",  32'(ref_req), 32'd0);
         check("noinit_debt", 32'(ref_debt), 32'd0);
         check("noinit_cmd",  32'(ref_cmd), 32'(NOP));
      end

      // Basic: init rises, grant tied high
      c0 = cyc;
      ref_init_end = 1'b1;
      push_burst(c0 + 781, 1);
      wait_until(c0 + 779);
      check("basic_req_early", 32'(ref_req), 32'd0);
      check("basic_debt_early", 32'(ref_debt), 32'd0);
      wait_until(c0 + 780);
      check("basic_req", 32'(ref_req), 32'd1);
      check("basic_debt1", 32'(ref_debt), 32'd1);
      wait_until(c0 + 781);
      check("basic_req_drop", 32'(ref_req), 32'd0);
      wait_until(c0 + 783);
      check("basic_debt_ar", 32'(ref_debt), 32'd1);
      wait_until(c0 + 784);
      check("basic_debt0", 32'(ref_debt), 32'd0);
      wait_until(c0 + 792);
      ref_en = 1'b0;

      // Postpone six intervals, then two back-to-back grants
      wait_until(c0 + T_REFI * 6 + 1);
      check("post_debt5", 32'(ref_debt), 32'd5);
      check("post_urg5", 32'(ref_urgent), 32'd0);
      wait_until(c0 + T_REFI * 7 + 1);
      check("post_debt6", 32'(ref_debt), 32'd6);
      check("post_urg6", 32'(ref_urgent), 32'd1);
      check("post_req", 32'(ref_req), 32'd1);
      ref_en = 1'b1;
      p = cyc + 1;
      push_burst(p, 4);
      push_burst(p + 32, 2);
      wait_until(p + 23);
      check("post_debt3", 32'(ref_debt), 32'd3);
      wait_until(p + 24);
      check("post_debt2", 32'(ref_debt), 32'd2);
      check("post_urg_clr", 32'(ref_urgent), 32'd0);
      wait_until(p + 31);
      check("post_rereq", 32'(ref_req), 32'd1);
      wait_until(p + 42);
      check("post_debt0", 32'(ref_debt), 32'd0);
      wait_until(p + 50);
      ref_en = 1'b0;

      // Overflow: nine ticks without a grant
      wait_until(c0 + T_REFI * 15);
      check("ovf_debt8", 32'(ref_debt), 32'd8);
      check("ovf_pre", 32'(ref_overflow), 32'd0);
      wait_until(c0 + T_REFI * 16 - 1);
      check("ovf_still0", 32'(ref_overflow), 32'd0);
      wait_until(c0 + T_REFI * 16);
      check("ovf_set", 32'(ref_overflow), 32'd1);
      check("ovf_sat", 32'(ref_debt), 32'd8);
      ref_en = 1'b1;
      p = cyc + 1;
      push_burst(p, 4);
      push_burst(p + 32, 4);
      wait_until(p + 64);
      ref_en = 1'b0;
      check("ovf_drained", 32'(ref_debt), 32'd0);
      check("ovf_sticky", 32'(ref_overflow), 32'd1);
      check("ovf_noreq", 32'(ref_req), 32'd0);

      // Simultaneous AR and tick with a one-refresh burst
      wait_until(c0 + T_REFI * 17);
      check("sim_debt1", 32'(ref_debt), 32'd1);
      wait_until(c0 + T_REFI * 18 - 4);
      ref_en = 1'b1;
      p = cyc + 1;
      push_burst(p, 1);
      wait_until(p);
      ref_en = 1'b0;
      wait_until(p + 2);
      check("sim_debt_ar", 32'(ref_debt), 32'd1);
      wait_until(p + 3);
      check("sim_debt_after", 32'(ref_debt), 32'd1);
      wait_until(p + 10);
      check("sim_rereq", 32'(ref_req), 32'd1);

      // Reset during tRFC
      wait_until(p + 12);
      ref_en = 1'b1;
      q = cyc + 1;
      push_ev(q, PRE);
      push_ev(q + T_RP, AR);
      wait_until(q + 4);
      ref_rst = 1'b1;
      ref_en  = 1'b0;
      wait_until(q + 5);
      ref_rst = 1'b0;
      check("mid_cmd",   32'(ref_cmd), 32'(NOP));
      check("mid_state", 32'(ref_state), 32'd0);
      check("mid_req",   32'(ref_req), 32'd0);
      check("mid_debt",  32'(ref_debt), 32'd0);
      check("mid_ovf",   32'(ref_overflow), 32'd0);
      check("mid_ack",   32'(ref_ack), 32'd0);
      check("mid_end",   32'(ref_end), 32'd0);
      check("mid_urg",   32'(ref_urgent), 32'd0);
      wait_until(q + 784);
      check("mid_timer_early", 32'(ref_debt), 32'd0);
      wait_until(q + 785);
      check("mid_timer_tick", 32'(ref_debt), 32'd1);
      check("mid_timer_req", 32'(ref_req), 32'd1);

      repeat (5) @(negedge ref_clk);
      check("sb_drain", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
